avalon_bram_burst: RTL and testbench

//  Avalon-MM agent giving an on-chip block RAM with per-byte write enables
//  and pipelined burst transfers (burst writes; burst reads with readdatavalid).

---
 rtl/avalon_bram_burst.sv | 119 +++++++++++
 tb/tb_avalon_bram_burst.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_bram_burst.sv
// Avalon-MM block RAM agent with per-byte write enables and pipelined bursts.
// Reads have one cycle of RAM latency; a new command is accepted on the last read beat.
module avalon_bram_burst #(
  parameter int DATA_W       = 32,
  parameter int RAM_ADD_W    = 8,
  parameter int BURSTCOUNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [RAM_ADD_W-1:0]    address,
  input  logic                    write,
  input  logic                    read,
  input  logic [DATA_W-1:0]       writedata,
  input  logic [DATA_W/8-1:0]     byteenable,
  input  logic [BURSTCOUNT_W-1:0] burstcount,
  output logic [DATA_W-1:0]       readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** RAM_ADD_W;
  localparam logic [BURSTCOUNT_W-1:0] MAXB  = BURSTCOUNT_W'(2 ** (BURSTCOUNT_W - 1));
  localparam logic [BURSTCOUNT_W-1:0] ONE_B = BURSTCOUNT_W'(1);
  localparam logic [RAM_ADD_W-1:0]    ONE_A = RAM_ADD_W'(1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  // Zero-length bursts count as one beat; oversize bursts clamp to MAXB.
  function automatic logic [BURSTCOUNT_W-1:0] eff_len(input logic [BURSTCOUNT_W-1:0] bc);
    if (bc == '0)
      return ONE_B;
    else if (bc > MAXB)
      return MAXB;
    else
      return bc;
  endfunction

  state_t                  state;
  logic [RAM_ADD_W-1:0]    wr_addr;
  logic [RAM_ADD_W-1:0]    rd_addr_p0;
  logic [BURSTCOUNT_W-1:0] remaining;
  logic [BURSTCOUNT_W-1:0] len;
  logic                    wr_en;
  logic [RAM_ADD_W-1:0]    wr_word;
  logic                    rd_en_p0;
  logic [RAM_ADD_W-1:0]    rd_word_p0;
  logic [DATA_W-1:0]       mem [DEPTH];

  assign len = eff_len(burstcount);

  always_comb begin
    wr_en      = write && (state == IDLE || state == WR_BURST);
    wr_word    = (state == IDLE) ? address : wr_addr;
    rd_en_p0   = (state == IDLE && read && !write) || (state == RD_BURST);
    rd_word_p0 = (state == IDLE) ? address : rd_addr_p0;
  end

  // RAM array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr_en && byteenable[i])
        mem[wr_word][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  // Read issue (p0) -> registered readdata/readdatavalid one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_addr       <= '0;
      rd_addr_p0    <= '0;
      remaining     <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      waitrequest   <= 1'b0;
    end else begin
      readdatavalid <= rd_en_p0;
      if (rd_en_p0)
        readdata <= mem[rd_word_p0];

      case (state)
        IDLE: begin
          if (write) begin
            wr_addr   <= address + ONE_A;
            remaining <= len - ONE_B;
            if (len > ONE_B)
              state <= WR_BURST;
          end else if (read) begin
            rd_addr_p0 <= address + ONE_A;
            remaining  <= len - ONE_B;
            if (len > ONE_B) begin
              state       <= RD_BURST;
              waitrequest <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (write) begin
            wr_addr   <= wr_addr + ONE_A;
            remaining <= remaining - ONE_B;
            if (remaining == ONE_B)
              state <= IDLE;
          end
        end
        RD_BURST: begin
          rd_addr_p0 <= rd_addr_p0 + ONE_A;
          remaining  <= remaining - ONE_B;
          if (remaining == ONE_B) begin
            state       <= IDLE;
            waitrequest <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Directed bench for avalon_bram_burst: vector table for single-word traffic,
// hand sequences for bursts, wrap, back-to-back reads, clamping and reset abort.
module tb_avalon_bram_burst;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  address = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [3:0]  burstcount = 4'd1;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_arr [8];

  avalon_bram_burst #(.DATA_W(32), .RAM_ADD_W(8), .BURSTCOUNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Accepts one read command in the current cycle and checks every beat.
  task automatic read_burst(input logic [7:0] a, input logic [3:0] bc, input int n, input string nm);
    address = a; burstcount = bc; read = 1'b1;
    tick();
    read = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_vld%0d", nm, k), {31'd0, readdatavalid}, 32'd1);
      chk($sformatf("%s_dat%0d", nm, k), readdata, exp_arr[k]);
      chk($sformatf("%s_wait%0d", nm, k), {31'd0, waitrequest}, (k < n - 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk($sformatf("%s_vld_end", nm), {31'd0, readdatavalid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 8'h40, 32'h11223344, 4'b1111, 32'h0};
    vecs[3] = '{1'b1, 8'h40, 32'hAABBCCDD, 4'b0101, 32'h0};
    vecs[4] = '{1'b0, 8'h40, 32'h0,        4'b0000, 32'h11BB33DD};
    vecs[5] = '{1'b1, 8'h40, 32'hFFFFFFFF, 4'b0000, 32'h0};
    vecs[6] = '{1'b0, 8'h40, 32'h0,        4'b0000, 32'h11BB33DD};
    vecs[7] = '{1'b1, 8'h04, 32'h00000055, 4'b1111, 32'h0};
    vecs[8] = '{1'b1, 8'hFB, 32'h000000AA, 4'b1111, 32'h0};
    vecs[9] = '{1'b0, 8'h10, 32'h0,        4'b0000, 32'hDEADBEEF};

    tick();
    tick();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_vld", {31'd0, readdatavalid}, 32'd0);
    chk("rst_wait", {31'd0, waitrequest}, 32'd0);
    #2 reset_n = 1'b1;
    tick();

    // Single-word table; each read follows the previous write by one cycle.
    for (int i = 0; i < 10; i++) begin
      address = vecs[i].addr; burstcount = 4'd1;
      writedata = vecs[i].data; byteenable = vecs[i].be;
      write = vecs[i].is_wr; read = !vecs[i].is_wr;
      tick();
      write = 1'b0; read = 1'b0;
      if (vecs[i].is_wr) begin
        chk($sformatf("v%0d_wr_vld", i), {31'd0, readdatavalid}, 32'd0);
      end else begin
        chk($sformatf("v%0d_rd_vld", i), {31'd0, readdatavalid}, 32'd1);
        chk($sformatf("v%0d_rd_dat", i), readdata, vecs[i].exp);
      end
    end
    tick();

    // Write burst of 8 wrapping past the top, stalled 2 cycles after beat 2.
    address = 8'hFC; burstcount = 4'd8; byteenable = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        write = 1'b0; address = 8'h77; burstcount = 4'd1;
        tick();
        tick();
      end
      write = 1'b1; writedata = 32'(k);
      chk($sformatf("wrb_wait%0d", k), {31'd0, waitrequest}, 32'd0);
      tick();
    end
    write = 1'b0;
    for (int k = 0; k < 8; k++) exp_arr[k] = 32'(k);
    read_burst(8'hFC, 4'd8, 8, "rdb8");

    exp_arr[0] = 32'h55;
    read_burst(8'h04, 4'd1, 1, "past_end");
    exp_arr[0] = 32'hAA;
    read_burst(8'hFB, 4'd1, 1, "before_start");

    // Two back-to-back 4-beat reads; second accepted on the first's last beat.
    address = 8'hFC; burstcount = 4'd4; read = 1'b1;
    tick();
    read = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_vld%0d", k), {31'd0, readdatavalid}, 32'd1);
      chk($sformatf("b2b_dat%0d", k), readdata, 32'(k));
      chk($sformatf("b2b_wait%0d", k), {31'd0, waitrequest}, (k == 3 || k == 7) ? 32'd0 : 32'd1);
      if (k == 3) begin
        address = 8'h00; burstcount = 4'd4; read = 1'b1;
      end
      tick();
      read = 1'b0;
    end
    chk("b2b_vld_end", {31'd0, readdatavalid}, 32'd0);

    for (int k = 0; k < 8; k++) exp_arr[k] = 32'(k);
    read_burst(8'hFC, 4'd0, 1, "bc0");
    read_burst(8'hFC, 4'd15, 8, "bc15");

    // Write wins over a simultaneous read.
    address = 8'h30; writedata = 32'hCAFEF00D; byteenable = 4'b1111; burstcount = 4'd1;
    write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    chk("wr_wins_vld", {31'd0, readdatavalid}, 32'd0);
    tick();
    chk("wr_wins_vld2", {31'd0, readdatavalid}, 32'd0);
    exp_arr[0] = 32'hCAFEF00D;
    read_burst(8'h30, 4'd1, 1, "wr_wins_rd");

    // Reset pulse during beat 2 of an 8-beat read.
    address = 8'hFC; burstcount = 4'd8; read = 1'b1;
    tick();
    read = 1'b0;
    chk("abort_beat0", readdata, 32'd0);
    tick();
    chk("abort_beat1", readdata, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_vld", {31'd0, readdatavalid}, 32'd0);
    chk("abort_wait", {31'd0, waitrequest}, 32'd0);
    chk("abort_dat", readdata, 32'd0);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_quiet%0d", k), {31'd0, readdatavalid}, 32'd0);
    end
    for (int k = 0; k < 8; k++) exp_arr[k] = 32'(k);
    read_burst(8'hFC, 4'd8, 8, "after_rst");
    exp_arr[0] = 32'h11BB33DD;
    read_burst(8'h40, 4'd1, 1, "after_rst_40");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
